// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Optional inter-byte timeout is enabled with UART_LOADER_TIMEOUT_EN.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CHECK
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/uart_loader_if.sv
// Byte-stream input and memory write port of the UART program loader.
// The loader side uses the master modport; the receiver/memory side uses slave.
interface uart_loader_if #(
  parameter int AW = 10
);
  logic [7:0]    rx_data;
  logic          rx_done_tick;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  modport master (
    input  rx_data, rx_done_tick,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_done_tick,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_loader_timer.sv
// Inter-byte idle counter for the UART loader; only instantiated when
// UART_LOADER_TIMEOUT_EN is defined.
module uart_loader_timer #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);
  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || !enable) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && (count_q == CW'(CYCLES - 1));

endmodule

// File: rtl/uart_loader.sv
// Framed UART program loader: SYNC, CNT_LO, CNT_HI, CNT*4 payload bytes, CHK.
// Define UART_LOADER_TIMEOUT_EN to abort frames that stall between bytes.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int AW             = 10,
  parameter int BASE_ADDR      = 0,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           reset,
  uart_loader_if.master  bus,
  output logic           busy,
  output logic           cpu_hold,
  output logic           load_done,
  output logic           load_err,
  output logic [1:0]     err_code
);

  localparam logic [16:0] MAX_CNT = 17'(MAX_WORDS);

  if (MAX_WORDS > (2 ** AW) - BASE_ADDR) begin : g_bad_max_words
    $error("uart_loader: MAX_WORDS does not fit in the address space");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_loader: TIMEOUT_CYCLES must be at least 2");
  end

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [23:0]   word_q, word_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          load_done_q, load_done_d;
  logic          load_err_q, load_err_d;
  logic [1:0]    err_code_q, err_code_d;

`ifdef UART_LOADER_TIMEOUT_EN
  logic timeout_hit;

  uart_loader_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .enable(state_q != IDLE),
    .clear (bus.rx_done_tick),
    .expire(timeout_hit)
  );
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    sum_d       = sum_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_done_d = 1'b0;
    load_err_d  = 1'b0;
    err_code_d  = err_code_q;

    if (bus.rx_done_tick) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_d    = CNT_LO;
            err_code_d = ERR_NONE;
            word_idx_d = '0;
            byte_idx_d = '0;
            sum_d      = '0;
          end
        end
        CNT_LO: begin
          cnt_d   = {8'h00, bus.rx_data};
          state_d = CNT_HI;
        end
        CNT_HI: begin
          cnt_d = {bus.rx_data, cnt_q[7:0]};
          if ({1'b0, cnt_d} > MAX_CNT) begin
            load_err_d = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = IDLE;
          end else if (cnt_d == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          sum_d      = sum_q + bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = bus.rx_data;
            2'd1: word_d[15:8]  = bus.rx_data;
            2'd2: word_d[23:16] = bus.rx_data;
            default: begin
              // Last lane goes straight to the write data; no need to store it.
              mem_we_d    = 1'b1;
              mem_addr_d  = AW'(BASE_ADDR) + AW'(word_idx_q);
              mem_wdata_d = {bus.rx_data, word_q};
              word_idx_d  = word_idx_q + 16'd1;
              if (word_idx_d == cnt_q) begin
                state_d = CHECK;
              end
            end
          endcase
        end
        CHECK: begin
          if (bus.rx_data == sum_q) begin
            load_done_d = 1'b1;
            err_code_d  = ERR_NONE;
          end else begin
            load_err_d = 1'b1;
            err_code_d = ERR_CSUM;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef UART_LOADER_TIMEOUT_EN
    else if (timeout_hit) begin
      load_err_d = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      sum_q       <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      sum_q       <= sum_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state_q != IDLE);
  assign cpu_hold      = busy;
  assign load_done     = load_done_q;
  assign load_err      = load_err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: a frame-level model predicts writes and
// end-of-frame pulses, and a negedge monitor checks the DUT against it.
module tb_uart_loader;

  localparam int AW        = 10;
  localparam int MAX_WORDS = 1024;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    int          idx;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int         idx;
    int         lat;
    logic       ok;
    logic [1:0] code;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy, cpu_hold, load_done, load_err;
  logic [1:0] err_code;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nwrites = 0;

  wr_t exp_wr[$];
  ev_t exp_ev[$];
  int  tick_cyc[$];

  uart_loader_if #(.AW(AW)) bus ();

  uart_loader #(
    .AW            (AW),
    .BASE_ADDR     (0),
    .MAX_WORDS     (MAX_WORDS),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level model: walks the byte list, predicting every write and the
  // end-of-frame result along with the index of the byte that triggers it.
  function automatic void buildModel(input byte_q_t b);
    int i;
    int cnt;
    int p;
    logic [7:0]  sum;
    logic [31:0] w;
    i = 0;
    while (i < b.size()) begin
      if (b[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 2 >= b.size()) return;
      cnt = int'({b[i+2], b[i+1]});
      if (cnt > MAX_WORDS) begin
        exp_ev.push_back('{idx: i + 2, lat: 1, ok: 1'b0, code: 2'b10});
        i += 3;
        continue;
      end
      sum = 8'h00;
      for (int k = 0; k < cnt; k++) begin
        p = i + 3 + 4 * k;
        if (p + 3 >= b.size()) return;
        w = {b[p+3], b[p+2], b[p+1], b[p]};
        sum = sum + b[p] + b[p+1] + b[p+2] + b[p+3];
        exp_wr.push_back('{idx: p + 3, addr: 10'(k), data: w});
      end
      p = i + 3 + 4 * cnt;
      if (p >= b.size()) return;
      if (b[p] == sum) exp_ev.push_back('{idx: p, lat: 1, ok: 1'b1, code: 2'b00});
      else             exp_ev.push_back('{idx: p, lat: 1, ok: 1'b0, code: 2'b01});
      i = p + 1;
    end
  endfunction

  task automatic applyStimulus(input byte_q_t b);
    tick_cyc.delete();
    foreach (b[i]) begin
      @(posedge clk); #1;
      bus.rx_data      = b[i];
      bus.rx_done_tick = 1'b1;
      tick_cyc.push_back(cyc);
      @(posedge clk); #1;
      bus.rx_done_tick = 1'b0;
      bus.rx_data      = 8'($urandom);
      repeat (i % 3) @(posedge clk);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((exp_wr.size() + exp_ev.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("expected_events_seen", exp_wr.size() + exp_ev.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic runFrame(input byte_q_t b);
    buildModel(b);
    applyStimulus(b);
    waitDrain(200);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.rx_done_tick = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_flags", {bus.mem_we, busy, cpu_hold, load_done, load_err}, 5'b0);
    checkOutput("rst_addr", bus.mem_addr, 10'h0);
    checkOutput("rst_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst_err_code", err_code, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: every write and every end-of-frame pulse must match the model.
  always @(negedge clk) begin
    wr_t w;
    ev_t e;
    if (!reset) begin
      if (bus.mem_we) begin
        nwrites++;
        if (exp_wr.size() == 0) begin
          checkOutput("unexpected_write", exp_wr.size(), 1);
        end else begin
          w = exp_wr.pop_front();
          checkOutput("write_addr", bus.mem_addr, w.addr);
          checkOutput("write_data", bus.mem_wdata, w.data);
          checkOutput("write_cycle", cyc, tick_cyc[w.idx] + 1);
        end
      end
      if (load_done || load_err) begin
        if (exp_ev.size() == 0) begin
          checkOutput("unexpected_pulse", exp_ev.size(), 1);
        end else begin
          e = exp_ev.pop_front();
          checkOutput("pulse_done", load_done, e.ok);
          checkOutput("pulse_err", load_err, !e.ok);
          checkOutput("pulse_err_code", err_code, e.code);
          checkOutput("pulse_cycle", cyc, tick_cyc[e.idx] + e.lat);
          checkOutput("pulse_busy_low", {busy, cpu_hold}, 2'b00);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byte_q_t b;
    int w0;

    bus.rx_data      = 8'h00;
    bus.rx_done_tick = 1'b0;
    doReset();

    // Basic one-word frame, model pinned against hand-computed values first.
    b = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
    buildModel(b);
    checkOutput("model_basic_data", exp_wr[0].data, 32'h12345678);
    checkOutput("model_basic_addr", exp_wr[0].addr, 10'h000);
    checkOutput("model_basic_ok", exp_ev[0].ok, 1'b1);
    w0 = nwrites;
    applyStimulus(b);
    waitDrain(200);
    checkOutput("basic_writes", nwrites - w0, 1);
    checkOutput("basic_err_code", err_code, 2'b00);
    checkOutput("basic_idle", {busy, cpu_hold}, 2'b00);

    // Bad checksum: the write still lands, then the frame reports 01.
    w0 = nwrites;
    runFrame('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h15});
    checkOutput("csum_writes", nwrites - w0, 1);
    checkOutput("csum_err_code", err_code, 2'b01);
    checkOutput("hold_wdata", bus.mem_wdata, 32'h12345678);
    checkOutput("hold_addr", bus.mem_addr, 10'h000);

    // Zero-length frame completes without writing.
    w0 = nwrites;
    runFrame('{8'hA5, 8'h00, 8'h00, 8'h00});
    checkOutput("zero_writes", nwrites - w0, 0);
    checkOutput("zero_err_code", err_code, 2'b00);

    // Count 1025 exceeds MAX_WORDS.
    b = '{8'hA5, 8'h01, 8'h04};
    buildModel(b);
    checkOutput("model_len_code", exp_ev[0].code, 2'b10);
    w0 = nwrites;
    applyStimulus(b);
    waitDrain(200);
    checkOutput("len_writes", nwrites - w0, 0);
    checkOutput("len_err_code", err_code, 2'b10);
    checkOutput("len_idle", busy, 1'b0);

    // Noise bytes are ignored and leave the sticky status alone.
    applyStimulus('{8'h00, 8'hFF, 8'h5A});
    repeat (2) @(posedge clk); #1;
    checkOutput("noise_busy", busy, 1'b0);
    checkOutput("noise_sticky_code", err_code, 2'b10);

    // Two-word frame.
    b = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
    buildModel(b);
    checkOutput("model_multi_w1", exp_wr[1].data, 32'h08070605);
    checkOutput("model_multi_a1", exp_wr[1].addr, 10'h001);
    w0 = nwrites;
    applyStimulus(b);
    waitDrain(200);
    checkOutput("multi_writes", nwrites - w0, 2);
    checkOutput("multi_err_code", err_code, 2'b00);

    // SYNC bytes inside the payload are plain data.
    w0 = nwrites;
    runFrame('{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h94});
    checkOutput("resync_writes", nwrites - w0, 1);
    checkOutput("resync_err_code", err_code, 2'b00);

    // Reset in the middle of a word: nothing is written.
    w0 = nwrites;
    runFrame('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56});
    checkOutput("midframe_busy", {busy, cpu_hold}, 2'b11);
    doReset();
    checkOutput("midframe_writes", nwrites - w0, 0);
    w0 = nwrites;
    runFrame('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14});
    checkOutput("after_reset_writes", nwrites - w0, 1);
    checkOutput("after_reset_addr", bus.mem_addr, 10'h000);

    // Stalled frame after the count bytes.
    b = '{8'hA5, 8'h01, 8'h00};
`ifdef UART_LOADER_TIMEOUT_EN
    // Counter clears on the edge that takes the byte, then needs 100 cycles.
    exp_ev.push_back('{idx: 2, lat: 101, ok: 1'b0, code: 2'b11});
    w0 = nwrites;
    applyStimulus(b);
    waitDrain(300);
    checkOutput("timeout_err_code", err_code, 2'b11);
    checkOutput("timeout_idle", busy, 1'b0);
    checkOutput("timeout_writes", nwrites - w0, 0);
`else
    applyStimulus(b);
    repeat (150) @(posedge clk); #1;
    checkOutput("stall_busy", {busy, cpu_hold}, 2'b11);
    checkOutput("stall_err_code", err_code, 2'b00);
    doReset();
    checkOutput("stall_reset_idle", busy, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Consumes the byte stream from the UART receiver stage (`rx_data` / `rx_done_tick`).
- Parses a framed program image and assembles little-endian 32-bit words.
- Writes each word into instruction/data memory through a simple write port.
- Holds the RISC-V core in reset while loading; reports done or error at frame end.

Parameters:
- AW, 10, word-address width of `mem_addr`.
- BASE_ADDR, 0, word address of the first payload word.
- MAX_WORDS, 1024, largest accepted word count; must be ≤ 2^AW − BASE_ADDR.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the receiver; valid when `rx_done_tick`=1.
- rx_done_tick  in  1  one-cycle strobe, one per received byte.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  AW  word address of the write.
- mem_wdata  out  32  write data.
- busy  out  1  high while a frame is in progress (any state except IDLE).
- cpu_hold  out  1  core reset request; equals `busy`.
- load_done  out  1  one-cycle pulse when a frame completes with a valid checksum.
- load_err  out  1  one-cycle pulse when a frame is aborted or fails.
- err_code  out  2  sticky status of the last frame:
  - 00 ok
  - 01 checksum mismatch
  - 10 count > MAX_WORDS
  - 11 timeout

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: all outputs 0; state IDLE; word index, byte index and checksum accumulator all 0.
- Frame format: SYNC (8'hA5), CNT_LO, CNT_HI, then CNT×4 payload bytes (LSB first per word), then CHK.
- Checksum: CHK = 8-bit sum, mod 256, of all payload bytes only.
- Bytes are processed only on cycles with `rx_done_tick`=1; `rx_data` is ignored otherwise.
- States:
  - IDLE: byte==A5 → CNT_LO; clear `err_code`, word index, byte index and sum. Any other byte is ignored.
  - CNT_LO: latch the low count byte → CNT_HI.
  - CNT_HI: latch the high byte to form 16-bit CNT.
    - CNT > MAX_WORDS → `load_err` pulse, `err_code`=10, → IDLE.
    - CNT==0 → CHECK.
    - Otherwise → DATA.
  - DATA: shift the byte into the word register at lane byte_idx; add it to sum; byte_idx increments mod 4.
    - On the 4th byte: the cycle after the tick, `mem_we`=1 for exactly one cycle.
    - During that strobe: `mem_addr` = BASE_ADDR + word_idx (mod 2^AW) and `mem_wdata` = the assembled word.
    - word_idx then increments. When word_idx reaches CNT → CHECK.
  - CHECK: compare the byte with sum.
    - Equal → `load_done` pulse, `err_code`=00.
    - Else → `load_err` pulse, `err_code`=01.
    - Both cases → IDLE.
- Latency: CHECK result pulse occurs one cycle after the CHK byte's tick.
- Writes are not rolled back on a checksum error. `cpu_hold` drops in the same cycle as the done/err pulse, so software must not rely on memory contents when `err_code`≠00.
- `mem_addr` / `mem_wdata` hold their last values when `mem_we`=0.
- Reset mid-frame: abort immediately. No further writes and no done/err pulse; the next frame restarts at BASE_ADDR.
- A SYNC byte inside a frame is treated as data (no resync).

Optional Feature:
- Macro: UART_LOADER_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in every non-IDLE state and clears on each `rx_done_tick`.
  - When it reaches TIMEOUT_CYCLES−1: `load_err` pulse, `err_code`=11, → IDLE. Memory already written is untouched.
  - A tick in the same cycle as expiry wins: the byte is processed and the counter clears.
- Without the macro: no counter; the FSM waits indefinitely and `err_code` 11 is never produced.

Decomposition:
- Package `uart_loader_pkg`:
  - state enum {IDLE, CNT_LO, CNT_HI, DATA, CHECK};
  - `SYNC_BYTE` = 8'hA5;
  - err_code localparams ERR_NONE, ERR_CSUM, ERR_LEN, ERR_TIMEOUT.
- One sub-module is natural: `uart_loader_timer` (load/clear/expire counter), instantiated only under UART_LOADER_TIMEOUT_EN.
- Word assembly and the FSM stay in the top module.

Test Plan:
- Basic load, BASE_ADDR=0: bytes A5 01 00 78 56 34 12 14 → one `mem_we` with addr 0, data 32'h12345678; then `load_done` pulse, `err_code`=00, `busy`/`cpu_hold` fall.
- Checksum error: same frame with CHK=15 → write of 32'h12345678 still occurs; `load_err` pulse, `err_code`=01.
- Length boundary, MAX_WORDS=1024:
  - A5 00 00 00 → `load_done`, zero writes.
  - A5 01 04 (1025) → `load_err`, `err_code`=10, zero writes, back to IDLE.
- Noise and multi-word: bytes 00 FF 5A then A5 02 00 + 8 payload bytes 01..08 + CHK 24 → first three bytes ignored (`busy`=0); writes 32'h04030201 @0 and 32'h08070605 @1, `load_done`.
- Reset mid-frame: assert `reset` after A5 01 00 78 56 → all outputs 0, no write. Then the full basic frame writes addr 0 correctly.
- Timeout, macro on, TIMEOUT_CYCLES=100: send A5 01 00 then stop → `load_err` 100 cycles after the last tick, `err_code`=11. With the macro off, the FSM stays in DATA with `busy`=1.
